ahb_lite_master_if: RTL and testbench

//  Single-outstanding AHB-Lite initiator that turns a simple valid/ready command into one AHB SINGLE transfer.

---
 rtl/ahb_lite_master_if_if.sv | 43 ++++
 rtl/ahb_lite_master_if.sv | 171 +++++++++++++++++
 tb/tb_ahb_lite_master_if.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_master_if_if.sv
// Command/response handshake plus AHB-Lite bus signals for one single-outstanding initiator.
// The master modport is the initiator's view; slave is the view of the engine and fabric around it.
interface ahb_lite_master_if_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  rsp_code;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_code,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_code,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_master_if.sv
// Single-outstanding AHB-Lite initiator: one command -> one SINGLE transfer -> one response pulse.
// Zero-wait latency accept->rsp_valid is 3 cycles; cmd_ready only in IDLE, responses are never stalled.
module ahb_lite_master_if #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
    input logic HCLK,
    input logic HRESETn,
    ahb_lite_master_if_if.master bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [1:0]  rsp_code_q, rsp_code_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        cmd_ready_q, cmd_ready_d;

    logic accept;
    logic legal;
    logic timeout_hit;

    assign accept = bus.cmd_valid && cmd_ready_q;
    assign legal  = (bus.cmd_size == 3'd0) ||
                    ((bus.cmd_size == 3'd1) && !bus.cmd_addr[0]) ||
                    ((bus.cmd_size == 3'd2) && (bus.cmd_addr[1:0] == 2'b00));

    // Fires on the edge that closes the TIMEOUT_CYCLES-th consecutive wait cycle of a phase.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q != S_IDLE) && !bus.HREADY &&
                         ((32'(wait_cnt_q) + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && legal) state_d = S_ADDR;
            S_ADDR: begin
                if (timeout_hit)     state_d = S_IDLE;
                else if (bus.HREADY) state_d = S_DATA;
            end
            S_DATA: begin
                if (timeout_hit || bus.HREADY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_IDLE) || (state_d != state_q)) wait_cnt_d = '0;
        else if (!bus.HREADY)                             wait_cnt_d = wait_cnt_q + CNT_W'(1);
        else                                              wait_cnt_d = wait_cnt_q;
    end

    always_comb begin
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_code_d  = 2'd0;
        rsp_rdata_d = 32'd0;
        cmd_ready_d = (state_d == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        haddr_d  = bus.cmd_addr;
                        hwrite_d = bus.cmd_write;
                        hsize_d  = bus.cmd_size;
                        wdata_d  = bus.cmd_wdata;
                        htrans_d = HTRANS_NONSEQ;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_code_d  = 2'd2;
                    end
                end
            end
            S_ADDR: begin
                if (timeout_hit) begin
                    htrans_d    = HTRANS_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_code_d  = 2'd3;
                end else if (bus.HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    if (hwrite_q) hwdata_d = wdata_q;
                end
            end
            S_DATA: begin
                if (timeout_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_code_d  = 2'd3;
                end else if (bus.HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.HRESP;
                    rsp_code_d  = bus.HRESP ? 2'd1 : 2'd0;
                    rsp_rdata_d = (!hwrite_q && !bus.HRESP) ? bus.HRDATA : 32'd0;
                end
            end
            default: htrans_d = HTRANS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            haddr_q     <= 32'd0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hwdata_q    <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_code_q  <= 2'd0;
            rsp_rdata_q <= 32'd0;
            cmd_ready_q <= 1'b1;
        end else begin
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_code_q  <= rsp_code_d;
            rsp_rdata_q <= rsp_rdata_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_code  = rsp_code_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.HBURST    = 3'b000;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HPROT     = HPROT_VAL;
endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Bench for ahb_lite_master_if: cycle-indexed timeline model of each transfer checked on the falling edge.
module tb_ahb_lite_master_if;
    localparam int TO = 8;

    logic HCLK;
    logic HRESETn;
    int   n_chk  = 0;
    int   n_fail = 0;

    ahb_lite_master_if_if bus ();

    ahb_lite_master_if #(.TIMEOUT_CYCLES(TO), .HPROT_VAL(4'b0011)) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic slave_idle();
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = $urandom;
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge HCLK);
            slave_idle();
            n_chk++; if (bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL %s idle htrans got %b want 00", name, bus.HTRANS); end
            n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s idle rsp_valid got %b want 0", name, bus.rsp_valid); end
            n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle cmd_ready got %b want 1", name, bus.cmd_ready); end
        end
    endtask

    // Call at a falling edge. Slave timing: a address-phase waits, d data-phase waits,
    // err gives a two-cycle ERROR ending the data phase. Returns at the response cycle.
    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata, input logic [31:0] rdata,
                           input int a, input int d, input logic err);
        bit          legal;
        int          rk, nonseq_end, final_k;
        logic [1:0]  exp_code, exp_trans;
        logic [31:0] exp_rdata;
        legal   = (size <= 3'd2) && ((addr % (32'd1 << size)) == 32'd0);
        final_k = a + 2 + d;
        if (!legal)        begin rk = 1;          nonseq_end = 0;     exp_code = 2'd2; end
        else if (a >= TO)  begin rk = TO + 1;     nonseq_end = TO;    exp_code = 2'd3; end
        else if (d >= TO)  begin rk = a + 2 + TO; nonseq_end = a + 1; exp_code = 2'd3; end
        else               begin rk = a + d + 3;  nonseq_end = a + 1; exp_code = err ? 2'd1 : 2'd0; end
        exp_rdata = (exp_code == 2'd0 && !wr) ? rdata : 32'd0;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_size  = size;
        bus.cmd_wdata = wdata;
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s accept cmd_ready got %b want 1", name, bus.cmd_ready); end
        @(posedge HCLK);
        for (int k = 1; k <= rk; k++) begin
            @(negedge HCLK);
            bus.cmd_valid = 1'b0;
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = $urandom;
            bus.cmd_wdata = $urandom;
            exp_trans = (k <= nonseq_end) ? 2'b10 : 2'b00;
            n_chk++; if (bus.HTRANS !== exp_trans) begin n_fail++; $display("FAIL %s k=%0d htrans got %b want %b", name, k, bus.HTRANS, exp_trans); end
            if (k <= nonseq_end) begin
                n_chk++; if (bus.HADDR !== addr) begin n_fail++; $display("FAIL %s k=%0d haddr got %h want %h", name, k, bus.HADDR, addr); end
                n_chk++; if (bus.HWRITE !== wr || bus.HSIZE !== size) begin n_fail++; $display("FAIL %s k=%0d hwrite/hsize got %b/%0d want %b/%0d", name, k, bus.HWRITE, bus.HSIZE, wr, size); end
            end
            if (legal && a < TO && wr && k >= a + 2 && k < rk) begin
                n_chk++; if (bus.HWDATA !== wdata) begin n_fail++; $display("FAIL %s k=%0d hwdata got %h want %h", name, k, bus.HWDATA, wdata); end
            end
            n_chk++; if (bus.rsp_valid !== (k == rk)) begin n_fail++; $display("FAIL %s k=%0d rsp_valid got %b want %b", name, k, bus.rsp_valid, (k == rk)); end
            n_chk++; if (bus.cmd_ready !== (k == rk)) begin n_fail++; $display("FAIL %s k=%0d cmd_ready got %b want %b", name, k, bus.cmd_ready, (k == rk)); end
            if (k == rk) begin
                n_chk++; if (bus.rsp_code !== exp_code) begin n_fail++; $display("FAIL %s rsp_code got %0d want %0d", name, bus.rsp_code, exp_code); end
                n_chk++; if (bus.rsp_err !== (exp_code != 2'd0)) begin n_fail++; $display("FAIL %s rsp_err got %b want %b", name, bus.rsp_err, (exp_code != 2'd0)); end
                n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL %s rsp_rdata got %h want %h", name, bus.rsp_rdata, exp_rdata); end
            end
            slave_idle();
            if (legal && k < rk) begin
                if (k <= nonseq_end) bus.HREADY = (a < TO) && (k == a + 1);
                else begin
                    bus.HREADY = (k == final_k);
                    bus.HRESP  = err && (k >= final_k - 1);
                    if (k == final_k) bus.HRDATA = rdata;
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'd0;
        bus.cmd_size  = 3'd0; bus.cmd_wdata = 32'd0;
        slave_idle();
        HRESETn = 1'b1;
        #3 HRESETn = 1'b0;
        #2;
        n_chk++; if (bus.HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset htrans got %b want 00", bus.HTRANS); end
        n_chk++; if (bus.HADDR !== 32'd0 || bus.HWDATA !== 32'd0) begin n_fail++; $display("FAIL reset haddr/hwdata got %h/%h want 0/0", bus.HADDR, bus.HWDATA); end
        n_chk++; if (bus.HSIZE !== 3'd0 || bus.HWRITE !== 1'b0) begin n_fail++; $display("FAIL reset hsize/hwrite got %0d/%b want 0/0", bus.HSIZE, bus.HWRITE); end
        n_chk++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid/err got %b/%b want 0/0", bus.rsp_valid, bus.rsp_err); end
        n_chk++; if (bus.rsp_code !== 2'd0 || bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset rsp_code/rdata got %0d/%h want 0/0", bus.rsp_code, bus.rsp_rdata); end
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready got %b want 1", bus.cmd_ready); end
        n_chk++; if (bus.HBURST !== 3'b000 || bus.HMASTLOCK !== 1'b0) begin n_fail++; $display("FAIL reset hburst/hmastlock got %b/%b want 000/0", bus.HBURST, bus.HMASTLOCK); end
        n_chk++; if (bus.HPROT !== 4'b0011) begin n_fail++; $display("FAIL reset hprot got %b want 0011", bus.HPROT); end
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        idle_cycles("post_reset", 2);
    endtask

    task automatic test_word_read();
        run_txn("word_read", 1'b0, 32'h0010_0004, 3'd2, 32'd0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        idle_cycles("word_read", 1);
    endtask

    task automatic test_write_waits();
        run_txn("write_waits", 1'b1, 32'h0010_0008, 3'd2, 32'h1234_5678, 32'd0, 0, 3, 1'b0);
        idle_cycles("write_waits", 1);
    endtask

    task automatic test_read_error();
        run_txn("read_error", 1'b0, 32'h0010_000C, 3'd2, 32'd0, 32'hCAFE_F00D, 0, 1, 1'b1);
        idle_cycles("read_error", 1);
    endtask

    task automatic test_illegal();
        run_txn("misaligned_half", 1'b0, 32'h0010_0001, 3'd1, 32'd0, 32'd0, 0, 0, 1'b0);
        idle_cycles("misaligned_half", 2);
        run_txn("size3", 1'b1, 32'h0010_0000, 3'd3, 32'h1111_2222, 32'd0, 0, 0, 1'b0);
        idle_cycles("size3", 2);
    endtask

    task automatic test_timeout();
        run_txn("timeout_addr", 1'b0, 32'h0010_0010, 3'd2, 32'd0, 32'h5555_AAAA, 30, 0, 1'b0);
        run_txn("after_timeout", 1'b0, 32'h0010_0014, 3'd2, 32'd0, 32'h0BAD_CAFE, 0, 0, 1'b0);
        run_txn("timeout_data", 1'b1, 32'h0010_0018, 3'd2, 32'h7777_8888, 32'd0, 1, 30, 1'b0);
        run_txn("edge_wait", 1'b0, 32'h0010_001C, 3'd2, 32'd0, 32'h0123_4567, TO - 1, TO - 1, 1'b0);
        idle_cycles("timeout", 1);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_0", 1'b1, 32'h0010_0040, 3'd0, 32'h0000_00AB, 32'd0, 0, 0, 1'b0);
        run_txn("b2b_1", 1'b0, 32'h0010_0042, 3'd1, 32'd0, 32'h0000_BEEF, 1, 0, 1'b0);
        run_txn("b2b_2", 1'b0, 32'h0010_0043, 3'd2, 32'd0, 32'd0, 0, 0, 1'b0);
        run_txn("b2b_3", 1'b0, 32'h0010_0044, 3'd2, 32'd0, 32'hF00D_F00D, 0, 2, 1'b0);
        idle_cycles("b2b", 1);
    endtask

    task automatic test_reset_mid();
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h0010_0020;
        bus.cmd_size  = 3'd2; bus.cmd_wdata = 32'hA5A5_5A5A;
        @(posedge HCLK);
        @(negedge HCLK);
        bus.cmd_valid = 1'b0;
        slave_idle();
        @(negedge HCLK);
        n_chk++; if (bus.HWDATA !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL reset_mid hwdata got %h want a5a55a5a", bus.HWDATA); end
        n_chk++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy cmd_ready got %b want 0", bus.cmd_ready); end
        bus.HREADY = 1'b0;
        #2 HRESETn = 1'b0;
        #1;
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid cmd_ready got %b want 1", bus.cmd_ready); end
        n_chk++; if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid htrans/rsp_valid got %b/%b want 00/0", bus.HTRANS, bus.rsp_valid); end
        n_chk++; if (bus.HWDATA !== 32'd0 || bus.HADDR !== 32'd0) begin n_fail++; $display("FAIL reset_mid hwdata/haddr got %h/%h want 0/0", bus.HWDATA, bus.HADDR); end
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        idle_cycles("reset_mid", 4);
        run_txn("after_reset_mid", 1'b0, 32'h0010_0024, 3'd2, 32'd0, 32'h3C3C_C3C3, 0, 0, 1'b0);
        idle_cycles("after_reset_mid", 1);
    endtask

    task automatic test_random();
        logic        wr, err;
        logic [2:0]  size;
        logic [31:0] addr;
        int          a, d;
        for (int i = 0; i < 60; i++) begin
            wr   = 1'($urandom);
            size = 3'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            a    = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 3);
            d    = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 3);
            err  = ($urandom_range(0, 3) == 0);
            if (err && d == 0) d = 1;
            run_txn("random", wr, addr, size, $urandom, $urandom, a, d, err);
            if ($urandom_range(0, 1) == 0) idle_cycles("random", $urandom_range(1, 2));
        end
        idle_cycles("random_end", 1);
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_write_waits();
        test_read_error();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
